// File: rtl/banco_registradores_pkg.sv
// -----------------------------------------------------------------------------
// pacote_mips
// Shared definitions for the MIPS register file and its neighbours:
//   DATA_W   - register / data port width
//   ADDR_W   - register address width (matches the write-select mux output)
//   NREG     - number of registers, always 2**ADDR_W
//   estado_t - register-file sequencer states
//   REG_ZERO - address of the hard-wired zero register
// -----------------------------------------------------------------------------
package pacote_mips;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 2 ** ADDR_W;

    typedef enum logic {
        LIMPANDO = 1'b0,
        OPERANDO = 1'b1
    } estado_t;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/banco_registradores_porta_leitura_bypass.sv
// -----------------------------------------------------------------------------
// porta_leitura_bypass
// One combinational read port of the register file. Selects, in priority:
// zero (while clearing or for register 0), the in-flight write data
// (write-first bypass), or the stored array word.
// Ports:
//   operando     in  1       register file has finished its clear sequence
//   endereco     in  ADDR_W  read address
//   escreve_reg  in  1       write enable of the current cycle
//   reg_escrita  in  ADDR_W  write address of the current cycle
//   dado_escrita in  DATA_W  write data of the current cycle
//   dado_mem     in  DATA_W  array word at endereco
//   dado         out DATA_W  read data
// -----------------------------------------------------------------------------
module porta_leitura_bypass
    import pacote_mips::*;
(
    input  logic              operando,
    input  logic [ADDR_W-1:0] endereco,
    input  logic              escreve_reg,
    input  logic [ADDR_W-1:0] reg_escrita,
    input  logic [DATA_W-1:0] dado_escrita,
    input  logic [DATA_W-1:0] dado_mem,
    output logic [DATA_W-1:0] dado
);

    always_comb begin
        dado = '0;
        if (!operando || endereco == REG_ZERO) begin
            dado = '0;
        end else if (escreve_reg && reg_escrita == endereco) begin
            // Same-cycle write is visible to the reader (write-first).
            dado = dado_escrita;
        end else begin
            dado = dado_mem;
        end
    end

endmodule

// File: rtl/banco_registradores.sv
// -----------------------------------------------------------------------------
// banco_registradores
// 32 x 32-bit MIPS register file: two combinational read ports, one
// synchronous write port. After reset a sequencer zeroes every entry, one per
// clock, before writes are accepted, so the array itself carries no reset.
// Ports:
//   clock         in  1       rising-edge clock
//   reset         in  1       synchronous, active-high reset
//   reg_leitura1  in  ADDR_W  read address, port 1 (rs)
//   reg_leitura2  in  ADDR_W  read address, port 2 (rt)
//   reg_escrita   in  ADDR_W  write address (from write-select mux)
//   dado_escrita  in  DATA_W  write data
//   escreve_reg   in  1       write enable
//   dado1         out DATA_W  read data, port 1
//   dado2         out DATA_W  read data, port 2
//   pronto        out 1       clear sequence completed
// -----------------------------------------------------------------------------
module banco_registradores
    import pacote_mips::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] reg_leitura1,
    input  logic [ADDR_W-1:0] reg_leitura2,
    input  logic [ADDR_W-1:0] reg_escrita,
    input  logic [DATA_W-1:0] dado_escrita,
    input  logic              escreve_reg,
    output logic [DATA_W-1:0] dado1,
    output logic [DATA_W-1:0] dado2,
    output logic              pronto
);

    estado_t           estado, estado_prox;
    logic [ADDR_W-1:0] contador, contador_prox;
    logic              limpa;
    logic              grava;

    logic [DATA_W-1:0] mem [NREG];

    // Sequencer state register (control only).
    always_ff @(posedge clock) begin
        estado   <= estado_prox;
        contador <= contador_prox;
    end

    always_comb begin
        estado_prox   = estado;
        contador_prox = contador;
        limpa         = 1'b0;
        grava         = 1'b0;
        if (reset) begin
            estado_prox   = LIMPANDO;
            contador_prox = '0;
        end else begin
            case (estado)
                LIMPANDO: begin
                    // Writes requested now are dropped, not deferred.
                    limpa         = 1'b1;
                    contador_prox = contador + ADDR_W'(1);
                    if (contador == ADDR_W'(NREG - 1)) begin
                        estado_prox = OPERANDO;
                    end
                end
                OPERANDO: begin
                    grava = escreve_reg && (reg_escrita != REG_ZERO);
                end
                default: begin
                    estado_prox = LIMPANDO;
                end
            endcase
        end
    end

    // pronto goes high on the same edge the sequencer enters OPERANDO and
    // low on the reset edge, so it is exactly the state bit.
    assign pronto = (estado == OPERANDO);

    // Array: one write per edge, either the clear sweep or a user write.
    always_ff @(posedge clock) begin
        if (limpa) begin
            mem[contador] <= '0;
        end else if (grava) begin
            mem[reg_escrita] <= dado_escrita;
        end
    end

    porta_leitura_bypass u_porta1 (
        .operando     (pronto),
        .endereco     (reg_leitura1),
        .escreve_reg  (escreve_reg),
        .reg_escrita  (reg_escrita),
        .dado_escrita (dado_escrita),
        .dado_mem     (mem[reg_leitura1]),
        .dado         (dado1)
    );

    porta_leitura_bypass u_porta2 (
        .operando     (pronto),
        .endereco     (reg_leitura2),
        .escreve_reg  (escreve_reg),
        .reg_escrita  (reg_escrita),
        .dado_escrita (dado_escrita),
        .dado_mem     (mem[reg_leitura2]),
        .dado         (dado2)
    );

endmodule

// File: tb/tb_banco_registradores.sv
module tb_banco_registradores;

    logic        clock;
    logic        reset;
    logic [4:0]  reg_leitura1;
    logic [4:0]  reg_leitura2;
    logic [4:0]  reg_escrita;
    logic [31:0] dado_escrita;
    logic        escreve_reg;
    logic [31:0] dado1;
    logic [31:0] dado2;
    logic        pronto;

    int tests = 0;
    int fails = 0;

    banco_registradores dut (
        .clock        (clock),
        .reset        (reset),
        .reg_leitura1 (reg_leitura1),
        .reg_leitura2 (reg_leitura2),
        .reg_escrita  (reg_escrita),
        .dado_escrita (dado_escrita),
        .escreve_reg  (escreve_reg),
        .dado1        (dado1),
        .dado2        (dado2),
        .pronto       (pronto)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vetor_t;

    vetor_t vetores [10];

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        tests++;
        if (atual !== esperado) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nome, atual, esperado);
        end
    endtask

    // One rising edge, returning at the following falling edge.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        escreve_reg  = 1'b0;
        reg_escrita  = 5'd0;
        dado_escrita = 32'd0;
        reg_leitura1 = 5'd0;
        reg_leitura2 = 5'd0;
    endtask

    // Counts low-reset edges, expecting pronto only after the 32nd.
    task automatic check_clear_sequence(input string nome);
        for (int e = 1; e <= 32; e++) begin
            step();
            check($sformatf("%s pronto edge %0d", nome, e), {31'd0, pronto}, (e == 32) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic check_all_zero(input string nome);
        escreve_reg = 1'b0;
        for (int a = 0; a < 32; a++) begin
            reg_leitura1 = 5'(a);
            reg_leitura2 = 5'(31 - a);
            #1;
            check($sformatf("%s dado1 r%0d", nome, a), dado1, 32'd0);
            check($sformatf("%s dado2 r%0d", nome, 31 - a), dado2, 32'd0);
        end
    endtask

    initial begin
        vetores[0] = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd0,  5'd8,  32'h00000000, 32'hDEADBEEF};
        vetores[1] = '{1'b0, 5'd0,  32'h00000000, 5'd8,  5'd8,  32'hDEADBEEF, 32'hDEADBEEF};
        vetores[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'h00000000, 32'h00000000};
        vetores[3] = '{1'b0, 5'd0,  32'h00000000, 5'd0,  5'd0,  32'h00000000, 32'h00000000};
        vetores[4] = '{1'b1, 5'd9,  32'h00000001, 5'd9,  5'd8,  32'h00000001, 32'hDEADBEEF};
        vetores[5] = '{1'b0, 5'd9,  32'hA5A5A5A5, 5'd9,  5'd9,  32'h00000001, 32'h00000001};
        vetores[6] = '{1'b1, 5'd9,  32'hA5A5A5A5, 5'd9,  5'd9,  32'hA5A5A5A5, 32'hA5A5A5A5};
        vetores[7] = '{1'b0, 5'd0,  32'h00000000, 5'd9,  5'd9,  32'hA5A5A5A5, 32'hA5A5A5A5};
        vetores[8] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd30, 32'hCAFEF00D, 32'h00000000};
        vetores[9] = '{1'b0, 5'd0,  32'h00000000, 5'd31, 5'd8,  32'hCAFEF00D, 32'hDEADBEEF};

        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        step();
        step();
        check("reset pronto", {31'd0, pronto}, 32'd0);
        reset = 1'b0;

        // Clear sequence with a write attempt to r3 at the 5th edge
        // (r3 has already been cleared at edge 4, so a leak would stick).
        for (int e = 1; e <= 32; e++) begin
            if (e == 5) begin
                escreve_reg  = 1'b1;
                reg_escrita  = 5'd3;
                dado_escrita = 32'hFFFFFFFF;
                reg_leitura1 = 5'd3;
                #1;
                check("clear forced dado1", dado1, 32'd0);
            end
            step();
            idle_inputs();
            check($sformatf("clear pronto edge %0d", e), {31'd0, pronto}, (e == 32) ? 32'd1 : 32'd0);
        end
        check_all_zero("after clear");
        reg_leitura1 = 5'd3;
        #1;
        check("dropped write r3", dado1, 32'd0);

        // Directed vectors: outputs checked before the edge, write commits at it.
        for (int i = 0; i < 10; i++) begin
            escreve_reg  = vetores[i].we;
            reg_escrita  = vetores[i].wa;
            dado_escrita = vetores[i].wd;
            reg_leitura1 = vetores[i].ra1;
            reg_leitura2 = vetores[i].ra2;
            #1;
            check($sformatf("vec%0d dado1", i), dado1, vetores[i].exp1);
            check($sformatf("vec%0d dado2", i), dado2, vetores[i].exp2);
            step();
        end
        idle_inputs();

        // Fill r1..r31 with their own index, read back.
        for (int r = 1; r < 32; r++) begin
            escreve_reg  = 1'b1;
            reg_escrita  = 5'(r);
            dado_escrita = 32'(r);
            step();
        end
        idle_inputs();
        for (int r = 1; r < 32; r++) begin
            reg_leitura1 = 5'(r);
            reg_leitura2 = 5'(32 - r);
            #1;
            check($sformatf("fill dado1 r%0d", r), dado1, 32'(r));
            check($sformatf("fill dado2 r%0d", 32 - r), dado2, 32'(32 - r));
        end

        // Reset mid-operation for one cycle.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midop reset pronto", {31'd0, pronto}, 32'd0);
        reg_leitura1 = 5'd17;
        #1;
        check("midop reset dado1", dado1, 32'd0);
        check_clear_sequence("midop");
        check_all_zero("after midop clear");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
